// File: rtl/ram_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ram_port_arbiter_pkg
//  Description : Shared types and constants for the single-port RAM arbiter:
//                response-owner encoding, starvation counter width and the
//                default starvation limit.
//  Revision    : 1.0 - initial release
// ============================================================================
package ram_port_arbiter_pkg;

  // Which requester owns the RAM read data coming back this cycle.
  typedef enum logic [1:0] {
    OWN_NONE  = 2'b00,
    OWN_FETCH = 2'b01,
    OWN_DATA  = 2'b10
  } owner_e;

  // Number of denied fetch cycles tolerated before fetch wins one arbitration.
  localparam int c_DEFAULT_STARVE_LIMIT = 3;

  // Starvation counter is 3 bits wide and saturates at all-ones.
  localparam int                 c_CNT_W   = 3;
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = '1;

  // Source of the read that was granted this cycle; writes and idle give NONE.
  function automatic owner_e next_owner(input logic f_gnt,
                                        input logic d_gnt,
                                        input logic d_we);
    owner_e w_own;
    w_own = OWN_NONE;
    if (f_gnt) begin
      w_own = OWN_FETCH;
    end else if (d_gnt && !d_we) begin
      w_own = OWN_DATA;
    end
    return w_own;
  endfunction

endpackage : ram_port_arbiter_pkg
`default_nettype wire

// File: rtl/ram_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : ram_port_arbiter_if
//  Description : Bundle of the fetch requester, data requester and RAM pin
//                signals around the RAM port arbiter. The slave modport is the
//                arbiter's view; the master modport is the surrounding CPU
//                (requesters plus the RAM returning read data).
//  Revision    : 1.0 - initial release
// ============================================================================
interface ram_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  // Fetch requester
  logic          f_req;
  logic [AW-1:0] f_addr;
  logic          f_gnt;
  logic          f_stall;
  logic          f_valid;
  logic [DW-1:0] f_word;

  // Data requester (memory_op RAM lane)
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_valid;
  logic [DW-1:0] d_rdata;

  // RAM pins
  logic [AW-1:0] ram_r_addr;
  logic [AW-1:0] ram_w_addr;
  logic [DW-1:0] ram_w_line;
  logic          ram_read;
  logic          ram_write;
  logic [DW-1:0] ram_r_line;

  modport slave (
    input  f_req, f_addr,
    output f_gnt, f_stall, f_valid, f_word,
    input  d_req, d_we, d_addr, d_wdata,
    output d_gnt, d_valid, d_rdata,
    output ram_r_addr, ram_w_addr, ram_w_line, ram_read, ram_write,
    input  ram_r_line
  );

  modport master (
    output f_req, f_addr,
    input  f_gnt, f_stall, f_valid, f_word,
    output d_req, d_we, d_addr, d_wdata,
    input  d_gnt, d_valid, d_rdata,
    input  ram_r_addr, ram_w_addr, ram_w_line, ram_read, ram_write,
    output ram_r_line
  );

endinterface : ram_port_arbiter_if
`default_nettype wire

// File: rtl/ram_port_arbiter_starve_counter.sv
`default_nettype none
// ============================================================================
//  Module      : arb_starve_counter
//  Description : Saturating count of consecutive cycles in which fetch asked
//                for the RAM and was denied. Flags when the count has reached
//                the limit so the arbiter can hand fetch one grant.
//  Revision    : 1.0 - initial release
// ============================================================================
module arb_starve_counter
  import ram_port_arbiter_pkg::*;
#(
  parameter int LIMIT = c_DEFAULT_STARVE_LIMIT
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_inc,
  input  wire logic i_clr,
  output logic      o_limit_hit
);

  localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(LIMIT);

  logic [c_CNT_W-1:0] r_cnt;

  // Count denied cycles; clear wins over increment and the count sticks at max.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != c_CNT_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_limit_hit = (r_cnt >= c_LIMIT);

endmodule : arb_starve_counter
`default_nettype wire

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ram_port_arbiter
//  Description : Shares one synchronous-read RAM port between instruction
//                fetch and the data lane. Data has priority; a starvation
//                counter forces a fetch grant after STARVE_LIMIT denials.
//                Grants are combinational; read data is steered back one cycle
//                later by a registered owner tag, and each side keeps its last
//                word in a hold register between responses.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = c_DEFAULT_STARVE_LIMIT
) (
  input  wire logic          clk,
  input  wire logic          rst,
  ram_port_arbiter_if.slave  bus
);

  logic          w_limit_hit;
  logic          w_f_gnt;
  logic          w_d_gnt;
  logic          w_d_rd_gnt;
  logic          w_d_wr_gnt;
  logic [AW-1:0] w_r_addr;
  logic [AW-1:0] w_w_addr;
  logic [DW-1:0] w_w_line;

  owner_e        r_owner;
  logic [DW-1:0] r_f_hold;
  logic [DW-1:0] r_d_hold;

  // Fetch wins when it is alone or has been starved long enough; reset blocks all grants.
  always_comb begin
    w_f_gnt = 1'b0;
    w_d_gnt = 1'b0;
    if (!rst) begin
      w_f_gnt = bus.f_req && (!bus.d_req || w_limit_hit);
      w_d_gnt = bus.d_req && !w_f_gnt;
    end
  end

  assign w_d_rd_gnt = w_d_gnt && !bus.d_we;
  assign w_d_wr_gnt = w_d_gnt &&  bus.d_we;

  arb_starve_counter #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk         (clk),
    .rst         (rst),
    .i_inc       (bus.f_req && !w_f_gnt),
    .i_clr       (w_f_gnt || !bus.f_req),
    .o_limit_hit (w_limit_hit)
  );

  // RAM port mux: undriven address/line outputs sit at zero.
  always_comb begin
    w_r_addr = '0;
    w_w_addr = '0;
    w_w_line = '0;
    if (w_f_gnt) begin
      w_r_addr = bus.f_addr;
    end else if (w_d_rd_gnt) begin
      w_r_addr = bus.d_addr;
    end
    if (w_d_wr_gnt) begin
      w_w_addr = bus.d_addr;
      w_w_line = bus.d_wdata;
    end
  end

  assign bus.f_gnt      = w_f_gnt;
  assign bus.d_gnt      = w_d_gnt;
  assign bus.f_stall    = !rst && bus.f_req && !w_f_gnt;
  assign bus.ram_read   = w_f_gnt || w_d_rd_gnt;
  assign bus.ram_write  = w_d_wr_gnt;
  assign bus.ram_r_addr = w_r_addr;
  assign bus.ram_w_addr = w_w_addr;
  assign bus.ram_w_line = w_w_line;

  // Tag who will receive next cycle's RAM read data; reset drops in-flight reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner <= OWN_NONE;
    end else begin
      r_owner <= next_owner(w_f_gnt, w_d_gnt, bus.d_we);
    end
  end

  // Capture each returning word so the requester sees a stable value afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_f_hold <= '0;
      r_d_hold <= '0;
    end else begin
      if (r_owner == OWN_FETCH) begin
        r_f_hold <= bus.ram_r_line;
      end
      if (r_owner == OWN_DATA) begin
        r_d_hold <= bus.ram_r_line;
      end
    end
  end

  // Response steering: live RAM data in the owner's cycle, hold value otherwise.
  always_comb begin
    bus.f_valid = 1'b0;
    bus.d_valid = 1'b0;
    bus.f_word  = '0;
    bus.d_rdata = '0;
    if (!rst) begin
      bus.f_valid = (r_owner == OWN_FETCH);
      bus.d_valid = (r_owner == OWN_DATA);
      bus.f_word  = (r_owner == OWN_FETCH) ? bus.ram_r_line : r_f_hold;
      bus.d_rdata = (r_owner == OWN_DATA)  ? bus.ram_r_line : r_d_hold;
    end
  end

endmodule : ram_port_arbiter
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_port_arbiter
//  Description : Scoreboard bench for ram_port_arbiter. A driver issues
//                directed then random requests, checks grants and RAM pins
//                against a reference model and queues the expected read
//                responses; an independent monitor pops and compares them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_port_arbiter;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int LIMIT = 3;

  typedef struct {
    int          due;
    bit          is_f;
    logic [31:0] word;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  ram_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  ram_port_arbiter #(
    .AW           (AW),
    .DW           (DW),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Cycle index shared by driver and monitor (changes only at rising edges)
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural RAM: unwritten locations read as addr+0x100, one-cycle read latency
  logic [31:0] ram_mem [logic [31:0]];
  always @(posedge clk) begin
    if (bus.ram_write) ram_mem[bus.ram_w_addr] = bus.ram_w_line;
    if (bus.ram_read)
      bus.ram_r_line <= ram_mem.exists(bus.ram_r_addr) ? ram_mem[bus.ram_r_addr]
                                                       : bus.ram_r_addr + 32'h100;
  end

  // Reference model state
  logic [31:0] mdl_mem [logic [31:0]];
  int          denied = 0;
  exp_t        q[$];
  logic [31:0] last_f = '0;
  logic [31:0] last_d = '0;

  function automatic logic [31:0] mdl_rd(input logic [31:0] a);
    return mdl_mem.exists(a) ? mdl_mem[a] : a + 32'h100;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input bit r, input bit fr, input logic [31:0] fa,
                      input bit dr, input bit dw, input logic [31:0] da,
                      input logic [31:0] dwd);
    bit fg, dg, rd, wr;
    logic [31:0] raddr, waddr, wline;
    exp_t e;
    @(negedge clk);
    rst         = r;
    bus.f_req   = fr;
    bus.f_addr  = fa;
    bus.d_req   = dr;
    bus.d_we    = dw;
    bus.d_addr  = da;
    bus.d_wdata = dwd;
    #1;
    if (r) begin
      fg = 0;
      dg = 0;
      if (q.size() > 0 && q[0].due == cyc) void'(q.pop_front());
      last_f = '0;
      last_d = '0;
    end else begin
      fg = fr && (!dr || denied >= LIMIT);
      dg = dr && !fg;
    end
    rd    = fg || (dg && !dw);
    wr    = dg && dw;
    raddr = fg ? fa : ((dg && !dw) ? da : 32'h0);
    waddr = wr ? da  : 32'h0;
    wline = wr ? dwd : 32'h0;
    chk("f_gnt",      bus.f_gnt,      fg);
    chk("d_gnt",      bus.d_gnt,      dg);
    chk("f_stall",    bus.f_stall,    !r && fr && !fg);
    chk("ram_read",   bus.ram_read,   rd);
    chk("ram_write",  bus.ram_write,  wr);
    chk("ram_r_addr", bus.ram_r_addr, raddr);
    chk("ram_w_addr", bus.ram_w_addr, waddr);
    chk("ram_w_line", bus.ram_w_line, wline);
    if (fg) begin
      e.due = cyc + 1; e.is_f = 1'b1; e.word = mdl_rd(fa);
      q.push_back(e);
    end
    if (dg && !dw) begin
      e.due = cyc + 1; e.is_f = 1'b0; e.word = mdl_rd(da);
      q.push_back(e);
    end
    if (wr) mdl_mem[da] = dwd;
    if (r || !fr || fg) denied = 0;
    else denied++;
  endtask

  task automatic idle();
    step(0, 0, 32'h0, 0, 0, 32'h0, 32'h0);
  endtask

  // Monitor: compares responses and hold values against the queued expectations
  initial begin
    exp_t e;
    bit   have, ef, ed;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        chk("rst_f_valid", bus.f_valid, 0);
        chk("rst_d_valid", bus.d_valid, 0);
        chk("rst_f_word",  bus.f_word,  0);
        chk("rst_d_rdata", bus.d_rdata, 0);
      end else begin
        have = (q.size() > 0) && (q[0].due == cyc);
        ef = 0;
        ed = 0;
        if (have) begin
          e = q.pop_front();
          ef = e.is_f;
          ed = !e.is_f;
          if (e.is_f) last_f = e.word;
          else        last_d = e.word;
        end
        chk("f_valid", bus.f_valid, ef);
        chk("d_valid", bus.d_valid, ed);
        chk("f_word",  bus.f_word,  last_f);
        chk("d_rdata", bus.d_rdata, last_d);
      end
    end
  end

  // Stimulus: directed scenarios followed by randomized traffic with occasional resets
  initial begin
    bus.f_req = 0; bus.f_addr = '0; bus.d_req = 0; bus.d_we = 0;
    bus.d_addr = '0; bus.d_wdata = '0;

    step(1, 0, 32'h0, 0, 0, 32'h0, 32'h0);
    step(1, 0, 32'h0, 0, 0, 32'h0, 32'h0);

    // Fetch only: words 0x100, 0x104, 0x108 come back
    step(0, 1, 32'h0, 0, 0, 32'h0, 32'h0);
    step(0, 1, 32'h4, 0, 0, 32'h0, 32'h0);
    step(0, 1, 32'h8, 0, 0, 32'h0, 32'h0);
    idle();

    // Data write then read-back of the same address
    step(0, 0, 32'h0, 1, 1, 32'h40, 32'hDEADBEEF);
    step(0, 0, 32'h0, 1, 0, 32'h40, 32'h0);
    idle();

    // Contention with reads: fetch gets every fourth cycle
    for (int i = 0; i < 8; i++) step(0, 1, 32'h200, 1, 0, 32'h80 + 32'(i * 4), 32'h0);
    idle();

    // Contention with writes: the write is held off on the forced fetch cycle
    for (int i = 0; i < 8; i++) step(0, 1, 32'h204, 1, 1, 32'h500 + 32'(i * 4), $urandom);
    idle();

    // Hold: fetched word stays on f_word through idle cycles
    step(0, 0, 32'h0, 1, 1, 32'h300, 32'h12345678);
    step(0, 1, 32'h300, 0, 0, 32'h0, 32'h0);
    repeat (5) idle();

    // Reset mid-operation discards the in-flight fetch
    step(0, 1, 32'h10, 0, 0, 32'h0, 32'h0);
    step(1, 1, 32'h14, 0, 0, 32'h0, 32'h0);
    step(0, 1, 32'h14, 0, 0, 32'h0, 32'h0);
    idle();

    // Back-to-back interleave fetch / data read / fetch
    step(0, 1, 32'h20, 0, 0, 32'h0, 32'h0);
    step(0, 0, 32'h0, 1, 0, 32'h40, 32'h0);
    step(0, 1, 32'h24, 0, 0, 32'h0, 32'h0);
    idle();

    // Randomized traffic over a small address pool
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 59) == 0,
           $urandom_range(0, 2) != 0, {25'h0, 5'($urandom_range(0, 31)), 2'b00},
           $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
           {25'h0, 5'($urandom_range(0, 31)), 2'b00}, $urandom);
    end
    repeat (3) idle();

    @(negedge clk);
    #3;
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_ram_port_arbiter
`default_nettype wire
